// File: rtl/mul_writeback_seq.sv
// mul_writeback_seq: sequences a 2N-bit product onto an N-bit register-file write port; optional flag registers via MUL_WB_FLAGS_EN
module mul_writeback_seq #(
  parameter int N  = 2,
  parameter int RA = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  in_product,
  input  logic            in_zero,
  input  logic            in_neg,
  input  logic            in_wide,
  input  logic [RA-1:0]   in_rd_lo,
  input  logic [RA-1:0]   in_rd_hi,
  output logic            wb_en,
  output logic [RA-1:0]   wb_addr,
  output logic [N-1:0]    wb_data,
  output logic            busy,
  output logic            done,
  output logic            flag_z,
  output logic            flag_n
);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;
  state_t            state_q, state_d;
  logic [2*N-1:0]    prod_q, prod_d;
  logic              wide_q, wide_d;
  logic [RA-1:0]     rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic              wb_en_q, wb_en_d;
  logic [RA-1:0]     wb_addr_q, wb_addr_d;
  logic [N-1:0]      wb_data_q, wb_data_d;
  logic              accept;
  assign in_ready = (state_q == IDLE) || (state_q == WR_HI) || (state_q == WR_LO && !wide_q);
  assign done     = (state_q == WR_LO && !wide_q) || (state_q == WR_HI);
  assign busy     = state_q != IDLE;
  assign accept   = in_valid && in_ready;
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  // Next state, holding-register load, and write-port values for the coming cycle
  always_comb begin
    state_d   = (state_q == WR_LO && wide_q) ? WR_HI : accept ? WR_LO : IDLE;
    prod_d    = accept ? in_product : prod_q;
    wide_d    = accept ? in_wide : wide_q;
    rd_lo_d   = accept ? in_rd_lo : rd_lo_q;
    rd_hi_d   = accept ? in_rd_hi : rd_hi_q;
    wb_en_d   = state_d != IDLE;
    wb_addr_d = state_d == WR_LO ? rd_lo_d : state_d == WR_HI ? rd_hi_d : '0;
    wb_data_d = state_d == WR_LO ? prod_d[N-1:0] : state_d == WR_HI ? prod_d[2*N-1:N] : '0;
  end
  // State, holding register and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prod_q    <= '0;
      wide_q    <= 1'b0;
      rd_lo_q   <= '0;
      rd_hi_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      wide_q    <= wide_d;
      rd_lo_q   <= rd_lo_d;
      rd_hi_q   <= rd_hi_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end
`ifdef MUL_WB_FLAGS_EN
  logic flag_z_q, flag_n_q;
  // Flags follow the most recently accepted product
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (accept) begin
      flag_z_q <= in_zero;
      flag_n_q <= in_neg;
    end
  end
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  logic unused_flags;
  assign unused_flags = in_zero ^ in_neg;
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif
endmodule

// File: tb/tb_mul_writeback_seq.sv
// tb_mul_writeback_seq: directed checks of the multiply write-back sequencer
module tb_mul_writeback_seq;
  localparam int N  = 2;
  localparam int RA = 4;
`ifdef MUL_WB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  in_product;
  logic            in_zero;
  logic            in_neg;
  logic            in_wide;
  logic [RA-1:0]   in_rd_lo;
  logic [RA-1:0]   in_rd_hi;
  logic            wb_en;
  logic [RA-1:0]   wb_addr;
  logic [N-1:0]    wb_data;
  logic            busy;
  logic            done;
  logic            flag_z;
  logic            flag_n;
  int n_chk = 0;
  int n_fail = 0;

  mul_writeback_seq #(.N(N), .RA(RA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_zero(in_zero), .in_neg(in_neg), .in_wide(in_wide),
    .in_rd_lo(in_rd_lo), .in_rd_hi(in_rd_hi), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy(busy), .done(done), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input string tag, input logic en, input logic [RA-1:0] a, input logic [N-1:0] d, input logic dn, input logic rdy);
    chk({tag, ".wb_en"}, 32'(wb_en), 32'(en));
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(a));
    chk({tag, ".wb_data"}, 32'(wb_data), 32'(d));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(en));
  endtask

  task automatic put(input logic [3:0] p, input logic w, input logic [3:0] lo, input logic [3:0] hi, input logic z, input logic n);
    in_valid = 1'b1; in_product = p; in_wide = w; in_rd_lo = lo; in_rd_hi = hi; in_zero = z; in_neg = n;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_zero = 1'b0; in_neg = 1'b0;
    in_wide = 1'b0; in_rd_lo = '0; in_rd_hi = '0;
    step(); step();
    rst = 1'b0;
    wb("reset", 0, 0, 0, 0, 1);
    chk("reset.flag_z", 32'(flag_z), 0);
    chk("reset.flag_n", 32'(flag_n), 0);

    put(4'b1001, 1, 1, 2, 0, 1);
    step(); in_valid = 1'b0;
    wb("wide.lo", 1, 1, 2'b01, 0, 0);
    chk("wide.flag_n", 32'(flag_n), 32'(FL));
    chk("wide.flag_z", 32'(flag_z), 0);
    step();
    wb("wide.hi", 1, 2, 2'b10, 1, 1);
    step();
    wb("wide.idle", 0, 0, 0, 0, 1);
    chk("wide.flag_n_hold", 32'(flag_n), 32'(FL));

    put(4'b0110, 0, 3, 0, 0, 0);
    step();
    wb("narrow0", 1, 3, 2'b10, 1, 1);
    chk("narrow0.flag_n", 32'(flag_n), 0);
    put(4'b0011, 0, 4, 0, 0, 0);
    step();
    wb("narrow1", 1, 4, 2'b11, 1, 1);
    put(4'b0000, 0, 5, 0, 1, 0);
    step(); in_valid = 1'b0;
    wb("narrow2", 1, 5, 2'b00, 1, 1);
    chk("narrow2.flag_z", 32'(flag_z), 32'(FL));
    step();
    wb("narrow.idle", 0, 0, 0, 0, 1);

    put(4'b1001, 1, 1, 2, 0, 0);
    step();
    put(4'b0111, 0, 6, 9, 0, 0);
    wb("bp.lo", 1, 1, 2'b01, 0, 0);
    step();
    wb("bp.hi", 1, 2, 2'b10, 1, 1);
    step(); in_valid = 1'b0;
    wb("bp.second", 1, 6, 2'b11, 1, 1);
    step();
    wb("bp.idle", 0, 0, 0, 0, 1);

    put(4'b1110, 1, 7, 7, 0, 0);
    step(); in_valid = 1'b0;
    wb("alias.lo", 1, 7, 2'b10, 0, 0);
    step();
    wb("alias.hi", 1, 7, 2'b11, 1, 1);
    step();
    wb("alias.idle", 0, 0, 0, 0, 1);

    put(4'b1001, 1, 1, 2, 1, 1);
    step(); in_valid = 1'b0;
    wb("rstmid.lo", 1, 1, 2'b01, 0, 0);
    chk("rstmid.flag_z_set", 32'(flag_z), 32'(FL));
    rst = 1'b1;
    step(); rst = 1'b0;
    wb("rstmid.after", 0, 0, 0, 0, 1);
    chk("rstmid.flag_z", 32'(flag_z), 0);
    chk("rstmid.flag_n", 32'(flag_n), 0);
    step();
    wb("rstmid.nohi", 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_writeback_seq.md
# mul_writeback_seq

- Sequencing stage directly downstream of the N-bit combinational multiplier in the processor datapath.
- Captures one 2N-bit product, its zero/negative flags and destination register indices through a valid/ready handshake.
- Drives the N-bit register-file write port: low half first, then high half when a wide result is requested.
- Provides back-to-back throughput and a done pulse so the control unit can track multiply retirement.

## Interface
- N, default 2: operand width; product is 2N bits, register-file data is N bits.
- RA, default 4: register-file address width.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a product this cycle.
- in_ready  out  1  block accepts the product this cycle.
- in_product  in  2N  multiplier product.
- in_zero  in  1  multiplier zero flag.
- in_neg  in  1  multiplier negative flag.
- in_wide  in  1  1 = write both halves; 0 = write low half only.
- in_rd_lo  in  RA  destination register for product[N-1:0].
- in_rd_hi  in  RA  destination register for product[2N-1:N].
- wb_en  out  1  register-file write enable.
- wb_addr  out  RA  register-file write address.
- wb_data  out  N  register-file write data.
- busy  out  1  a transaction is held (state not IDLE).
- done  out  1  one-cycle pulse in a transaction's final write cycle.
- flag_z  out  1  registered zero flag (see Configuration).
- flag_n  out  1  registered negative flag (see Configuration).

## Operation
- **Accept rule:** a transfer occurs on a rising edge where in_valid && in_ready. At that edge the block latches product, wide, rd_lo and rd_hi into a one-entry holding register.
- **States:**
  - IDLE: no transaction held.
  - WR_LO: low-half write in progress.
  - WR_HI: high-half write in progress.
- **Transitions:**
  - IDLE → WR_LO on accept.
  - WR_LO → WR_HI if the held wide bit is 1.
  - WR_LO with wide = 0: → WR_LO on a new accept, else → IDLE.
  - WR_HI: → WR_LO on a new accept, else → IDLE.
- **Outputs per state:**
  - WR_LO: wb_en = 1, wb_addr = rd_lo, wb_data = product[N-1:0].
  - WR_HI: wb_en = 1, wb_addr = rd_hi, wb_data = product[2N-1:N].
  - IDLE: wb_en = 0; wb_addr and wb_data = 0.
- **in_ready:**
  - 1 in IDLE.
  - 1 in WR_LO when held wide = 0.
  - 1 in WR_HI.
  - 0 in WR_LO when held wide = 1.
  - Combinational from state only; never depends on in_valid.
- **done:** 1 in WR_LO with wide = 0, and in WR_HI; 0 otherwise.
- **busy:** equals (state != IDLE).
- **Widths:** in_product is split without sign or zero extension. wb_data is an exact slice of the held product.
- **rd_lo == rd_hi with wide = 1:** both writes are issued; the high half lands last and wins. No merging.
- **Unaccepted input:** in_valid while in_ready = 0 is ignored. Upstream must hold its data stable until accepted.
- **Reset mid-transaction:** the transaction is abandoned. The next cycle is IDLE with wb_en = 0; the pending high-half write is never issued.

## Timing
- Reset values: state IDLE; wb_en, wb_addr, wb_data, busy, done, flag_z, flag_n = 0; in_ready = 1.
- Latency: accept at edge k → wb_en high during cycle k+1 (low half). High half, if wide, in cycle k+2.
- Throughput:
  - Narrow: one result per cycle, continuous.
  - Wide: one result per two cycles; in_ready toggles 0/1 under continuous wide traffic.
- All outputs except in_ready and done are registered. in_ready and done are decoded from registered state only.

## Configuration
- Macro MUL_WB_FLAGS_EN.
- **Defined:** flag_z and flag_n load in_zero and in_neg on every accept edge and hold until the next accept or reset.
- **Undefined:** flag_z and flag_n are constant 0, no flag register is synthesized, and in_zero/in_neg are unused.

## Test plan
All scenarios use N = 2 and RA = 4.
- **Wide write:** accept product 4'b1001, wide = 1, rd_lo = 1, rd_hi = 2, zero = 0, neg = 1. → Cycle+1: wb 1 ← 2'b01. Cycle+2: wb 2 ← 2'b10, done = 1. With macro: flag_n = 1, flag_z = 0.
- **Narrow back-to-back:** in_valid held for 3 cycles with products 4'b0110, 4'b0011, 4'b0000 (wide = 0), rd_lo = 3, 4, 5. → wb_en high 3 consecutive cycles writing 2'b10, 2'b11, 2'b00. in_ready stays 1. done high each cycle.
- **Backpressure:** present a second product during WR_LO of a wide transaction. → in_ready = 0 that cycle; the second product is accepted on the WR_HI edge and its low-half write follows immediately.
- **Aliased destinations:** wide = 1, rd_lo = rd_hi = 7, product 4'b1110. → Two writes to register 7: 2'b10, then 2'b11.
- **Reset mid-op:** assert rst during WR_LO of a wide transaction. → Next cycle: IDLE, wb_en = 0, no high-half write, all outputs at reset values.
- **Macro off:** repeat the wide-write scenario without MUL_WB_FLAGS_EN. → Identical writes; flag_z = flag_n = 0 throughout.
